// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and the round-robin pick for the fetch/data memory arbiter.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    localparam logic [7:0] ERR_DATA_DEFAULT = 8'hFF;

    // On a tie the port that did not win last time gets the bus.
    function automatic logic pick_port(input logic f_req, input logic d_req,
                                       input logic last_grant);
        if (f_req && d_req) begin
            return ~last_grant;
        end else if (d_req) begin
            return PORT_DATA;
        end else begin
            return PORT_FETCH;
        end
    endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one single-port memory between fetch and data ports.
// Handshake: requesters hold their request level until a one-cycle ack; memory strobe holds until mem_ready_i.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int             AW       = 8,
    parameter int             DW       = 8,
    parameter int             TIMEOUT  = 15,
    parameter logic [DW-1:0]  ERR_DATA = DW'(ERR_DATA_DEFAULT)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          f_req_i,
    input  logic [AW-1:0] f_addr_i,
    output logic          f_ack_o,
    output logic [DW-1:0] f_rdata_o,
    input  logic          d_rd_i,
    input  logic          d_wr_i,
    input  logic [AW-1:0] d_addr_i,
    input  logic [DW-1:0] d_wdata_i,
    output logic          d_ack_o,
    output logic [DW-1:0] d_rdata_o,
    output logic          mem_rd_o,
    output logic          mem_wr_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    input  logic          mem_ready_i,
    output logic          err_o,
    output state_e        state_o
);

    state_e        state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic          owner_q, owner_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          err_q, err_d;

    logic d_req;
    logic winner;
    logic timeout_hit;

    assign d_req       = d_rd_i | d_wr_i;
    assign timeout_hit = (TIMEOUT != 0) && ((int'(cnt_q) + 1) == TIMEOUT);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            last_grant_q <= PORT_FETCH;
            owner_q      <= PORT_FETCH;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        cnt_d        = cnt_q;
        err_d        = 1'b0;
        winner       = PORT_FETCH;

        case (state_q)
            IDLE: begin
                if (f_req_i || d_req) begin
                    winner       = pick_port(f_req_i, d_req, last_grant_q);
                    owner_d      = winner;
                    last_grant_d = winner;
                    cnt_d        = '0;
                    state_d      = BUSY;
                    if (winner == PORT_DATA) begin
                        // Read+write together resolves to a write and is flagged.
                        addr_d  = d_addr_i;
                        wr_d    = d_wr_i;
                        wdata_d = d_wr_i ? d_wdata_i : '0;
                        err_d   = d_rd_i & d_wr_i;
                    end else begin
                        addr_d  = f_addr_i;
                        wr_d    = 1'b0;
                        wdata_d = '0;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 16'd1;
                if (mem_ready_i) begin
                    rdata_d = wr_q ? '0 : mem_rdata_i;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    rdata_d = ERR_DATA;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_rd_o    = (state_q == BUSY) && !wr_q;
    assign mem_wr_o    = (state_q == BUSY) && wr_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign f_ack_o     = (state_q == RESP) && (owner_q == PORT_FETCH);
    assign d_ack_o     = (state_q == RESP) && (owner_q == PORT_DATA);
    assign f_rdata_o   = rdata_q;
    assign d_rdata_o   = rdata_q;
    assign err_o       = err_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed scoreboard bench for mem_bus_arbiter: expected memory ops and acks queued by the driver, checked by a monitor.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       f_req_i = 1'b0;
  logic [7:0] f_addr_i = '0;
  logic       f_ack_o;
  logic [7:0] f_rdata_o;
  logic       d_rd_i = 1'b0;
  logic       d_wr_i = 1'b0;
  logic [7:0] d_addr_i = '0;
  logic [7:0] d_wdata_i = '0;
  logic       d_ack_o;
  logic [7:0] d_rdata_o;
  logic       mem_rd_o;
  logic       mem_wr_o;
  logic [7:0] mem_addr_o;
  logic [7:0] mem_wdata_o;
  logic [7:0] mem_rdata_i = 8'hEE;
  logic       mem_ready_i = 1'b0;
  logic       err_o;
  state_e     state_o;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.AW(8), .DW(8), .TIMEOUT(15), .ERR_DATA(8'hFF)) dut (
    .clk(clk), .rstn(rstn),
    .f_req_i(f_req_i), .f_addr_i(f_addr_i), .f_ack_o(f_ack_o), .f_rdata_o(f_rdata_o),
    .d_rd_i(d_rd_i), .d_wr_i(d_wr_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_ack_o(d_ack_o), .d_rdata_o(d_rdata_o),
    .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i),
    .err_o(err_o), .state_o(state_o)
  );

  typedef struct packed { logic wr; logic [7:0] addr; logic [7:0] wdata; } mem_op_t;
  typedef struct packed { logic port; logic [7:0] rdata; } ack_t;

  mem_op_t exp_mem_q[$];
  ack_t    exp_ack_q[$];

  int checks = 0;
  int errors = 0;
  int err_cnt = 0;
  int mem_delay = 0;
  bit mem_never = 1'b0;
  logic [7:0] mem_data = 8'h00;
  int busy_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_mem(input logic wr, input logic [7:0] addr, input logic [7:0] wdata);
    mem_op_t m;
    m.wr = wr; m.addr = addr; m.wdata = wdata;
    exp_mem_q.push_back(m);
  endtask

  task automatic push_ack(input logic port, input logic [7:0] rdata);
    ack_t a;
    a.port = port; a.rdata = rdata;
    exp_ack_q.push_back(a);
  endtask

  // Memory model: ready after mem_delay strobe cycles, or never.
  always @(negedge clk) begin
    if (mem_rd_o || mem_wr_o) begin
      if (!mem_never && busy_cnt == mem_delay) begin
        mem_ready_i = 1'b1;
        mem_rdata_i = mem_data;
      end else begin
        mem_ready_i = 1'b0;
        mem_rdata_i = 8'hEE;
      end
      busy_cnt++;
    end else begin
      mem_ready_i = 1'b0;
      mem_rdata_i = 8'hEE;
      busy_cnt = 0;
    end
  end

  logic       prev_strobe = 1'b0;
  logic [7:0] cur_addr = '0;

  always @(negedge clk) begin
    mem_op_t m;
    ack_t    a;
    logic    strobe;
    strobe = mem_rd_o | mem_wr_o;
    if (err_o) err_cnt++;
    if (strobe) check("strobe_exclusive", 32'(mem_rd_o & mem_wr_o), 0);
    if (strobe && !prev_strobe) begin
      if (exp_mem_q.size() == 0) begin
        check("unexpected_mem_op", 32'(strobe), 0);
      end else begin
        m = exp_mem_q.pop_front();
        check("mem_wr", 32'(mem_wr_o), 32'(m.wr));
        check("mem_rd", 32'(mem_rd_o), 32'(!m.wr));
        check("mem_addr", 32'(mem_addr_o), 32'(m.addr));
        check("mem_wdata", 32'(mem_wdata_o), 32'(m.wdata));
        cur_addr = m.addr;
      end
    end else if (strobe) begin
      check("mem_addr_hold", 32'(mem_addr_o), 32'(cur_addr));
    end
    prev_strobe = strobe;
    if (f_ack_o || d_ack_o) begin
      if (exp_ack_q.size() == 0) begin
        check("unexpected_ack", {30'd0, f_ack_o, d_ack_o}, 0);
      end else begin
        a = exp_ack_q.pop_front();
        check("f_ack", 32'(f_ack_o), 32'(a.port == PORT_FETCH));
        check("d_ack", 32'(d_ack_o), 32'(a.port == PORT_DATA));
        if (a.port == PORT_FETCH) check("f_rdata", 32'(f_rdata_o), 32'(a.rdata));
        else                      check("d_rdata", 32'(d_rdata_o), 32'(a.rdata));
      end
    end
  end

  // Waits for the next ack, counting negedges since the call and strobe cycles seen.
  task automatic wait_ack(input string name, input int budget, output int lat, output int strobes);
    lat = 0;
    strobes = 0;
    while (lat < budget) begin
      @(negedge clk);
      lat++;
      if (mem_rd_o || mem_wr_o) strobes++;
      if (d_ack_o && d_rd_i && !d_wr_i && lat == 2) d_addr_i = d_addr_i;
      if (f_ack_o || d_ack_o) break;
    end
    if (!(f_ack_o || d_ack_o)) begin
      checks++;
      errors++;
      $display("FAIL %s_ack_wait actual=no_ack expected=ack_within_%0d", name, budget);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int strb;
    int e0;

    repeat (3) @(negedge clk);
    check("rst_state", 32'(state_o), 32'(IDLE));
    check("rst_mem_rd", 32'(mem_rd_o), 0);
    check("rst_mem_wr", 32'(mem_wr_o), 0);
    check("rst_f_ack", 32'(f_ack_o), 0);
    check("rst_d_ack", 32'(d_ack_o), 0);
    check("rst_err", 32'(err_o), 0);
    check("rst_mem_addr", 32'(mem_addr_o), 0);
    rstn = 1'b1;
    @(negedge clk);

    // Fetch only, memory ready in first BUSY cycle
    mem_delay = 0; mem_data = 8'h5A;
    push_mem(1'b0, 8'h10, 8'h00);
    push_ack(PORT_FETCH, 8'h5A);
    f_addr_i = 8'h10; f_req_i = 1'b1;
    wait_ack("fetch", 20, lat, strb);
    f_req_i = 1'b0;
    check("fetch_latency", lat, 2);
    check("fetch_strobes", strb, 1);
    @(negedge clk);

    // Both held: data first, then strict alternation
    mem_data = 8'h77;
    push_mem(1'b1, 8'h30, 8'hC3); push_ack(PORT_DATA, 8'h00);
    push_mem(1'b0, 8'h20, 8'h00); push_ack(PORT_FETCH, 8'h77);
    push_mem(1'b1, 8'h30, 8'hC3); push_ack(PORT_DATA, 8'h00);
    push_mem(1'b0, 8'h20, 8'h00); push_ack(PORT_FETCH, 8'h77);
    f_addr_i = 8'h20; f_req_i = 1'b1;
    d_addr_i = 8'h30; d_wdata_i = 8'hC3; d_wr_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ack("alternate", 20, lat, strb);
      check("alternate_latency", lat, (k == 0) ? 2 : 3);
    end
    f_req_i = 1'b0; d_wr_i = 1'b0;
    @(negedge clk);

    // Data read, ready delayed 4 cycles, address changed mid-transaction
    mem_delay = 4; mem_data = 8'hA5;
    push_mem(1'b0, 8'h40, 8'h00);
    push_ack(PORT_DATA, 8'hA5);
    d_addr_i = 8'h40; d_wdata_i = 8'h11; d_rd_i = 1'b1;
    lat = 0; strb = 0;
    while (lat < 30 && !(f_ack_o || d_ack_o)) begin
      @(negedge clk);
      lat++;
      if (mem_rd_o || mem_wr_o) strb++;
      if (lat == 2) d_addr_i = 8'h99;
    end
    if (!(f_ack_o || d_ack_o)) check("delayed_ack_seen", 0, 1);
    d_rd_i = 1'b0;
    check("delayed_latency", lat, 6);
    check("delayed_strobes", strb, 5);
    @(negedge clk);

    // Memory never ready: timeout after 15 BUSY cycles
    mem_never = 1'b1;
    e0 = err_cnt;
    push_mem(1'b0, 8'h50, 8'h00);
    push_ack(PORT_DATA, 8'hFF);
    d_addr_i = 8'h50; d_rd_i = 1'b1;
    wait_ack("timeout", 40, lat, strb);
    d_rd_i = 1'b0;
    check("timeout_latency", lat, 16);
    check("timeout_strobes", strb, 15);
    @(negedge clk);
    check("timeout_err_pulses", err_cnt - e0, 1);
    mem_never = 1'b0;

    // Read and write together: performed as write, flagged
    mem_delay = 0;
    e0 = err_cnt;
    push_mem(1'b1, 8'h60, 8'h3C);
    push_ack(PORT_DATA, 8'h00);
    d_addr_i = 8'h60; d_wdata_i = 8'h3C; d_rd_i = 1'b1; d_wr_i = 1'b1;
    wait_ack("rdwr", 20, lat, strb);
    d_rd_i = 1'b0; d_wr_i = 1'b0;
    check("rdwr_latency", lat, 2);
    @(negedge clk);
    check("rdwr_err_pulses", err_cnt - e0, 1);

    // Reset during BUSY abandons the transaction
    mem_delay = 10;
    push_mem(1'b0, 8'h70, 8'h00);
    f_addr_i = 8'h70; f_req_i = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_reset_busy", 32'(state_o), 32'(BUSY));
    rstn = 1'b0;
    #1;
    check("rst_mid_mem_rd", 32'(mem_rd_o), 0);
    check("rst_mid_mem_wr", 32'(mem_wr_o), 0);
    check("rst_mid_f_ack", 32'(f_ack_o), 0);
    check("rst_mid_state", 32'(state_o), 32'(IDLE));
    f_req_i = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    check("post_reset_state", 32'(state_o), 32'(IDLE));
    check("exp_mem_q_empty", exp_mem_q.size(), 0);
    check("exp_ack_q_empty", exp_ack_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
